// File: rtl/ex_stage_pipe.sv
// rtl/ex_stage_pipe.sv - MIPS execute stage: forwarding, ALU, iterative multiplier, EX/MEM register
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid_i          ID/EX holds a valid instruction
//   a_i, b_i, imm_i     rs / rt operands and sign-extended immediate
//                       (imm_i[5:0] = funct, imm_i[10:6] = shamt)
//   rd_i, reg_write_i   destination register and writeback enable
//   alu_src_i, alu_op_i operand-B select and ALU operation class
//   fwd_a_i, fwd_b_i    forwarding selects (10 EX/MEM, 01 MEM/WB, else register)
//   exmem_fwd_i         EX/MEM forwarding value
//   memwb_fwd_i         MEM/WB forwarding value
//   flush_i             squash the instruction currently in EX
//   stall_o             EX busy; hold upstream stages
//   out_valid_o         EX/MEM holds a valid instruction
//   result_o, zero_o    registered result and (result == 0)
//   wdata_o             registered forwarded rt (store data)
//   rd_o, reg_write_o   registered destination and writeback enable

module ex_stage_pipe #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic [WIDTH-1:0]  imm_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              reg_write_i,
    input  logic              alu_src_i,
    input  logic [1:0]        alu_op_i,
    input  logic [1:0]        fwd_a_i,
    input  logic [1:0]        fwd_b_i,
    input  logic [WIDTH-1:0]  exmem_fwd_i,
    input  logic [WIDTH-1:0]  memwb_fwd_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              out_valid_o,
    output logic [WIDTH-1:0]  result_o,
    output logic [WIDTH-1:0]  wdata_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              reg_write_o,
    output logic              zero_o
);

    // The immediate is widened so funct/shamt fields exist even for narrow datapaths.
    localparam int IW = (WIDTH < 11) ? 11 : WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [WIDTH-1:0]    acc_q;
    logic [WIDTH-1:0]    mcand_q;
    logic [WIDTH-1:0]    mplier_q;
    logic                neg_q;
    logic [REG_AW-1:0]   mul_rd_q;
    logic                mul_rw_q;

    logic                out_valid_q;
    logic [WIDTH-1:0]    result_q;
    logic [WIDTH-1:0]    wdata_q;
    logic [REG_AW-1:0]   rd_q;
    logic                reg_write_q;
    logic                zero_q;

    logic [IW-1:0]       imm_x;
    logic [5:0]          funct;
    logic [4:0]          shamt;
    logic                unused_imm;

    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b0;
    logic [WIDTH-1:0]    op_b;
    logic [WIDTH-1:0]    alu_res;

    logic                is_mult;
    logic                mul_accept;
    logic                cnt_one;
    logic                a_neg;
    logic                b_neg;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;
    logic [WIDTH-1:0]    acc_d;
    logic [WIDTH-1:0]    prod_d;

    assign imm_x      = IW'(imm_i);
    assign funct      = imm_x[5:0];
    assign shamt      = imm_x[10:6];
    assign unused_imm = ^imm_x;

    // Forwarding muxes; 11 falls back to the register operand.
    always_comb begin
        op_a = a_i;
        case (fwd_a_i)
            2'b10:   op_a = exmem_fwd_i;
            2'b01:   op_a = memwb_fwd_i;
            default: op_a = a_i;
        endcase
    end

    always_comb begin
        op_b0 = b_i;
        case (fwd_b_i)
            2'b10:   op_b0 = exmem_fwd_i;
            2'b01:   op_b0 = memwb_fwd_i;
            default: op_b0 = b_i;
        endcase
    end

    assign op_b = alu_src_i ? imm_i : op_b0;

    // Single-cycle ALU. MULT is not produced here: with the multiplier
    // disabled it decodes to the default zero result.
    always_comb begin
        alu_res = '0;
        case (alu_op_i)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b10: begin
                case (funct)
                    6'h20:   alu_res = op_a + op_b;
                    6'h22:   alu_res = op_a - op_b;
                    6'h24:   alu_res = op_a & op_b;
                    6'h25:   alu_res = op_a | op_b;
                    6'h26:   alu_res = op_a ^ op_b;
                    6'h27:   alu_res = ~(op_a | op_b);
                    6'h2A:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                    6'h2B:   alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
                    6'h00:   alu_res = op_b0 << shamt;
                    6'h02:   alu_res = op_b0 >> shamt;
                    6'h03:   alu_res = $signed(op_b0) >>> shamt;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    assign is_mult    = (alu_op_i == 2'b10) && (funct == 6'h18);
    assign mul_accept = (state_q == S_IDLE) && in_valid_i && is_mult
                        && (MUL_EN != 0) && !flush_i;
    assign cnt_one    = (cnt_q == CW'(1));

    // Magnitude multiply; the sign is reapplied to the low WIDTH bits,
    // which equals the low half of the signed product modulo 2^WIDTH.
    assign a_neg  = op_a[WIDTH-1];
    assign b_neg  = op_b0[WIDTH-1];
    assign a_mag  = a_neg ? -op_a : op_a;
    assign b_mag  = b_neg ? -op_b0 : op_b0;
    assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_d = neg_q ? -acc_d : acc_d;

    // Stall drops in the final multiply cycle so upstream advances on the
    // same edge that writes the product; gated by reset so it clears at once.
    assign stall_o = rst_n & (mul_accept
                     | ((state_q == S_MUL) && !flush_i && !cnt_one));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            neg_q       <= 1'b0;
            mul_rd_q    <= '0;
            mul_rw_q    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    result_q    <= alu_res;
                    zero_q      <= (alu_res == '0);
                    wdata_q     <= op_b0;
                    rd_q        <= rd_i;
                    out_valid_q <= in_valid_i & !flush_i & !mul_accept;
                    reg_write_q <= reg_write_i & in_valid_i & !flush_i & !mul_accept;
                    if (mul_accept) begin
                        state_q  <= S_MUL;
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        neg_q    <= a_neg ^ b_neg;
                        cnt_q    <= CW'(WIDTH);
                        acc_q    <= '0;
                        mul_rd_q <= rd_i;
                        mul_rw_q <= reg_write_i;
                    end
                end
                S_MUL: begin
                    out_valid_q <= 1'b0;
                    reg_write_q <= 1'b0;
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q - CW'(1);
                        if (cnt_one) begin
                            state_q     <= S_IDLE;
                            result_q    <= prod_d;
                            zero_q      <= (prod_d == '0);
                            rd_q        <= mul_rd_q;
                            out_valid_q <= 1'b1;
                            reg_write_q <= mul_rw_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign wdata_o     = wdata_q;
    assign rd_o        = rd_q;
    assign reg_write_o = reg_write_q;
    assign zero_o      = zero_q;

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
Parametrised execute stage for the 5-stage pipelined MIPS core. It replaces the purely combinational EX logic with four pieces:
- forwarding operand selection;
- an extended single-cycle ALU;
- an iterative multi-cycle multiplier with pipeline stall;
- a registered EX/MEM output stage.

It sits between the ID/EX register and the MEM stage, and drives the hazard unit's stall input.

Parameters:
WIDTH, 32, datapath width in bits (power of two, >=8)
REG_AW, 5, register-address width for rd
MUL_EN, 1, 1 = MULT funct supported; 0 = MULT decodes as default (result 0, no stall)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ID/EX holds a valid instruction
a  in  WIDTH  rs operand from ID/EX
b  in  WIDTH  rt operand from ID/EX
imm  in  WIDTH  sign-extended immediate; imm[5:0] = funct, imm[10:6] = shamt
rd_in  in  REG_AW  destination register
reg_write_in  in  1  writeback enable from control
alu_src  in  1  1 = operand B is imm
alu_op  in  2  00 add, 01 sub, 10 R-type (funct decode), 11 reserved (result 0)
fwd_a  in  2  00 a, 10 exmem_fwd, 01 memwb_fwd, 11 a
fwd_b  in  2  same encoding for b
exmem_fwd  in  WIDTH  EX/MEM ALU result for forwarding
memwb_fwd  in  WIDTH  MEM/WB writeback data for forwarding
flush  in  1  synchronous squash of the current EX instruction
stall  out  1  hold IF/ID/ID-EX; EX is busy
out_valid  out  1  EX/MEM holds a valid instruction
result  out  WIDTH  registered ALU/MUL result
wdata  out  WIDTH  registered forwarded rt (store data; pre-alu_src mux)
rd_out  out  REG_AW  registered destination
reg_write_out  out  1  registered writeback enable, gated by out_valid
zero  out  1  registered (result == 0), for BEQ

Behaviour:
Reset:
- Async, on rst_n low.
- All outputs 0; state = IDLE; multiplier counter, accumulator and operand registers 0.

Operand mux and funct decode:
- opA = fwd_a mux; opB0 = fwd_b mux; opB = alu_src ? imm : opB0.
- funct values (alu_op = 10):
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor
  - 0x2A slt (signed), 0x2B sltu
  - 0x00 sll opB0 by shamt; 0x02 srl; 0x03 sra
  - 0x18 mult: low WIDTH bits of opA*opB0, signed
  - others: result 0
- All arithmetic is modulo 2^WIDTH; overflow is ignored.

Timing:
- Single-cycle ops: the EX/MEM register updates on the clock edge after in_valid, so latency is 1.
- wdata = opB0; rd_out = rd_in; reg_write_out = reg_write_in & in_valid.

States: IDLE, MUL.
- IDLE -> MUL: in_valid & MULT & MUL_EN & !flush.
  - Capture |opA|, |opB0| and the sign.
  - Counter = WIDTH; accumulator = 0.
  - stall is combinational: 1 in this cycle.
  - EX/MEM loads a bubble (out_valid = 0).
- MUL:
  - Each cycle: shift-add one multiplier bit; counter decrements; stall = 1; EX/MEM holds a bubble.
  - When counter reaches 1, that cycle's edge loads the sign-corrected product with rd/reg_write captured at accept. out_valid = 1, and the FSM returns to IDLE.
  - stall deasserts in that same final cycle, so upstream advances on the same edge.
  - Total latency: WIDTH+1 edges from accept to out_valid; stall is high for WIDTH cycles.
- While in MUL:
  - a, b, imm, fwd_* and in_valid are ignored; the captured operands are used.
  - Forward-source changes have no effect.
- flush:
  - In IDLE: the next EX/MEM entry is a bubble (out_valid = 0, reg_write_out = 0).
  - In MUL: abort to IDLE next edge; stall drops the same cycle; no result is produced.
- flush has priority over accept and over MUL completion.
- in_valid = 0: EX/MEM loads a bubble. result/zero may update, but out_valid = 0 and reg_write_out = 0.
- Reset mid-MUL: immediate return to IDLE; stall = 0.
- Back-to-back MULT: the second is accepted in the cycle after completion (IDLE).

Test Plan:
1. Reset with rst_n = 0 mid-sequence -> all outputs 0, stall = 0 within the same cycle (async).
2. alu_op = 10, funct 0x22, a = 5, b = 7 -> next edge result = 0xFFFFFFFE, zero = 0, out_valid = 1. funct 0x2A with the same operands -> result = 1. funct 0x2B, a = 0xFFFFFFFF, b = 1 -> result = 0.
3. Forwarding: fwd_a = 10, exmem_fwd = 100, fwd_b = 01, memwb_fwd = 23, funct 0x20 -> result = 123, wdata = 23. alu_src = 1, imm = 4, alu_op = 00 -> result = 104, wdata = 23.
4. MULT a = 0xFFFFFFFD (-3), b = 7 -> stall high for 32 cycles, out_valid = 0 during them; on edge 33 result = 0xFFFFFFEB, rd_out = rd_in at accept, reg_write_out = 1.
5. MULT accepted, flush pulsed at cycle 10 -> stall drops that cycle, no out_valid with the MULT rd; the next add completes normally at 1-cycle latency.
6. sra funct 0x03, b = 0x80000000, shamt = 4 -> result = 0xF8000000. Same input with funct 0x02 -> 0x08000000. WIDTH = 8 instance: mult 0x0F*0x11 -> result 0xFF after 9 edges.
